// File: rtl/cache_bus_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module   : cache_arb_pkg
// Purpose  : Shared state encodings, owner codes and defaults for the cache
//            bus arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_arb_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_ADDR = 2'd1,
      W_RESP = 2'd2
   } wr_state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   // 32-byte cache line
   localparam int LINE_OFF_DEF = 5;

endpackage

`default_nettype wire

// File: rtl/cache_bus_arbiter_if.sv
//------------------------------------------------------------------------------
// Module   : cache_bus_arbiter_if
// Purpose  : Cache request / grant / response and bus adapter handshakes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface cache_bus_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              IReqValid;
   logic              IReqUncache;
   logic [ADDR_W-1:0] IReqAddr;
   logic              IReqReady;
   logic              IRespValid;

   logic              DReqValid;
   logic              DReqUncache;
   logic [ADDR_W-1:0] DReqAddr;
   logic              DReqReady;
   logic              DRespValid;

   logic              DWrValid;
   logic              DWrUncache;
   logic [ADDR_W-1:0] DWrAddr;
   logic              DWrReady;
   logic              DWrDone;

   logic              BusRdValid;
   logic [ADDR_W-1:0] BusRdAddr;
   logic              BusRdUncache;
   logic              BusRdSel;
   logic              BusRdAccept;
   logic              BusRdDone;

   logic              BusWrValid;
   logic [ADDR_W-1:0] BusWrAddr;
   logic              BusWrUncache;
   logic              BusWrAccept;
   logic              BusWrDone;

   // Arbiter side
   modport master (
      input  IReqValid, IReqUncache, IReqAddr,
      output IReqReady, IRespValid,
      input  DReqValid, DReqUncache, DReqAddr,
      output DReqReady, DRespValid,
      input  DWrValid, DWrUncache, DWrAddr,
      output DWrReady, DWrDone,
      output BusRdValid, BusRdAddr, BusRdUncache, BusRdSel,
      input  BusRdAccept, BusRdDone,
      output BusWrValid, BusWrAddr, BusWrUncache,
      input  BusWrAccept, BusWrDone
   );

   // Cache / adapter side
   modport slave (
      output IReqValid, IReqUncache, IReqAddr,
      input  IReqReady, IRespValid,
      output DReqValid, DReqUncache, DReqAddr,
      input  DReqReady, DRespValid,
      output DWrValid, DWrUncache, DWrAddr,
      input  DWrReady, DWrDone,
      input  BusRdValid, BusRdAddr, BusRdUncache, BusRdSel,
      output BusRdAccept, BusRdDone,
      input  BusWrValid, BusWrAddr, BusWrUncache,
      output BusWrAccept, BusWrDone
   );

endinterface

`default_nettype wire

// File: rtl/cache_bus_arbiter_rd_grant_pick.sv
//------------------------------------------------------------------------------
// Module   : rd_grant_pick
// Purpose  : Combinational read winner select; one-hot {DCache, ICache} grant.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rd_grant_pick (
   input  logic       i_i_valid,
   input  logic       i_d_elig,
   input  logic       i_starve_full,
   output logic [1:0] o_grant
);

   // ICache has priority unless the DCache has waited out the starvation limit
   always_comb begin
      o_grant = 2'b00;
      if (i_i_valid && i_d_elig) begin
         o_grant = i_starve_full ? 2'b10 : 2'b01;
      end else if (i_i_valid) begin
         o_grant = 2'b01;
      end else if (i_d_elig) begin
         o_grant = 2'b10;
      end
   end

endmodule

`default_nettype wire

// File: rtl/cache_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module   : cache_bus_arbiter
// Purpose  : ICache/DCache read arbiter and DCache write sequencer in front of
//            a single bus adapter. CACHE_ARB_RAW_CHECK_EN enables blocking of
//            DCache reads that would overtake a pending write.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_bus_arbiter
   import cache_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_OFF   = LINE_OFF_DEF,
   parameter int STARVE_MAX = 4
) (
   input  logic                Clk,
   input  logic                Rest,
   cache_bus_arbiter_if.master bus
);

   localparam int                 c_CNT_W      = $clog2(STARVE_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_STARVE_MAX = c_CNT_W'(STARVE_MAX);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

   rd_state_t           r_rd_state;
   logic [ADDR_W-1:0]   r_rd_addr;
   logic                r_rd_unc;
   logic                r_rd_owner;
   logic                r_rd_valid;

   wr_state_t           r_wr_state;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic                r_wr_unc;
   logic                r_wr_valid;

   logic [c_CNT_W-1:0]  r_starve_cnt;

   logic                w_rd_idle;
   logic                w_wr_grant;
   logic                w_hazard;
   logic                w_i_valid;
   logic                w_d_elig;
   logic [1:0]          w_rd_grant;

   // Grants are suppressed while reset is held so every output reads 0
   assign w_rd_idle  = !Rest && (r_rd_state == R_IDLE);
   assign w_wr_grant = !Rest && (r_wr_state == W_IDLE) && bus.DWrValid;

`ifdef CACHE_ARB_RAW_CHECK_EN
   logic                w_wr_pending;
   logic [ADDR_W-1:0]   w_pend_addr;

   // A write granted this cycle already counts as pending, so it beats a
   // same-cycle read of its line
   assign w_wr_pending = (r_wr_state != W_IDLE) || w_wr_grant;
   assign w_pend_addr  = (r_wr_state != W_IDLE) ? r_wr_addr : bus.DWrAddr;
   assign w_hazard     = w_wr_pending &&
                         (bus.DReqUncache ||
                          (w_pend_addr[ADDR_W-1:LINE_OFF] == bus.DReqAddr[ADDR_W-1:LINE_OFF]));
`else
   assign w_hazard = 1'b0;
`endif

   assign w_i_valid = w_rd_idle && bus.IReqValid;
   assign w_d_elig  = w_rd_idle && bus.DReqValid && !w_hazard;

   rd_grant_pick u_rd_grant_pick (
      .i_i_valid     (w_i_valid),
      .i_d_elig      (w_d_elig),
      .i_starve_full (r_starve_cnt == c_STARVE_MAX),
      .o_grant       (w_rd_grant)
   );

   // Read sequencer
   always_ff @(posedge Clk) begin
      if (Rest) begin
         r_rd_state <= R_IDLE;
         r_rd_addr  <= '0;
         r_rd_unc   <= 1'b0;
         r_rd_owner <= OWN_I;
         r_rd_valid <= 1'b0;
      end else begin
         case (r_rd_state)
            R_IDLE: begin
               if (w_rd_grant[1]) begin
                  r_rd_state <= R_ADDR;
                  r_rd_addr  <= bus.DReqAddr;
                  r_rd_unc   <= bus.DReqUncache;
                  r_rd_owner <= OWN_D;
                  r_rd_valid <= 1'b1;
               end else if (w_rd_grant[0]) begin
                  r_rd_state <= R_ADDR;
                  r_rd_addr  <= bus.IReqAddr;
                  r_rd_unc   <= bus.IReqUncache;
                  r_rd_owner <= OWN_I;
                  r_rd_valid <= 1'b1;
               end
            end
            R_ADDR: begin
               if (bus.BusRdAccept) begin
                  r_rd_state <= R_DATA;
                  r_rd_valid <= 1'b0;
               end
            end
            R_DATA: begin
               if (bus.BusRdDone) begin
                  r_rd_state <= R_IDLE;
               end
            end
            default: begin
               r_rd_state <= R_IDLE;
               r_rd_valid <= 1'b0;
            end
         endcase
      end
   end

   // Write sequencer
   always_ff @(posedge Clk) begin
      if (Rest) begin
         r_wr_state <= W_IDLE;
         r_wr_addr  <= '0;
         r_wr_unc   <= 1'b0;
         r_wr_valid <= 1'b0;
      end else begin
         case (r_wr_state)
            W_IDLE: begin
               if (w_wr_grant) begin
                  r_wr_state <= W_ADDR;
                  r_wr_addr  <= bus.DWrAddr;
                  r_wr_unc   <= bus.DWrUncache;
                  r_wr_valid <= 1'b1;
               end
            end
            W_ADDR: begin
               if (bus.BusWrAccept) begin
                  r_wr_state <= W_RESP;
                  r_wr_valid <= 1'b0;
               end
            end
            W_RESP: begin
               if (bus.BusWrDone) begin
                  r_wr_state <= W_IDLE;
               end
            end
            default: begin
               r_wr_state <= W_IDLE;
               r_wr_valid <= 1'b0;
            end
         endcase
      end
   end

   // Consecutive ICache wins while a DCache read is waiting
   always_ff @(posedge Clk) begin
      if (Rest) begin
         r_starve_cnt <= '0;
      end else if (!bus.DReqValid || w_rd_grant[1]) begin
         r_starve_cnt <= '0;
      end else if (w_rd_grant[0] && (r_starve_cnt != c_STARVE_MAX)) begin
         r_starve_cnt <= r_starve_cnt + c_CNT_ONE;
      end
   end

   assign bus.IReqReady    = w_rd_grant[0];
   assign bus.DReqReady    = w_rd_grant[1];
   assign bus.DWrReady     = w_wr_grant;

   assign bus.IRespValid   = !Rest && (r_rd_state == R_DATA) && bus.BusRdDone && (r_rd_owner == OWN_I);
   assign bus.DRespValid   = !Rest && (r_rd_state == R_DATA) && bus.BusRdDone && (r_rd_owner == OWN_D);
   assign bus.DWrDone      = !Rest && (r_wr_state == W_RESP) && bus.BusWrDone;

   assign bus.BusRdValid   = r_rd_valid;
   assign bus.BusRdAddr    = r_rd_addr;
   assign bus.BusRdUncache = r_rd_unc;
   assign bus.BusRdSel     = r_rd_owner;

   assign bus.BusWrValid   = r_wr_valid;
   assign bus.BusWrAddr    = r_wr_addr;
   assign bus.BusWrUncache = r_wr_unc;

endmodule

`default_nettype wire

// File: doc/cache_bus_arbiter.md
# cache_bus_arbiter

Request arbiter and transaction sequencer between the ICache/DCache miss logic and the single AXI bus adapter. It grants one read at a time to either the ICache or the DCache, with ICache priority bounded by a starvation limit. It sequences one DCache write at a time, and routes completion pulses back to the owning requester. It also blocks DCache reads that would overtake a pending write to the same line.

## Interface
Parameters:
- ADDR_W, 32, request address width
- LINE_OFF, 5, line offset bits (32-byte line) used for hazard compare
- STARVE_MAX, 4, consecutive ICache grants allowed while a DCache read waits

Ports:
- Clk  in  1  clock, all state on rising edge
- Rest  in  1  reset, synchronous, active-high
- IReqValid / IReqUncache  in  1 / 1  ICache read request, uncached flag
- IReqAddr  in  ADDR_W  ICache read address
- IReqReady  out  1  one-cycle grant pulse; request accepted this cycle
- IRespValid  out  1  ICache read complete pulse
- DReqValid / DReqUncache / DReqAddr / DReqReady / DRespValid  same as ICache set, for DCache reads
- DWrValid / DWrUncache  in  1 / 1  DCache write request, uncached flag
- DWrAddr  in  ADDR_W  write address
- DWrReady  out  1  write grant pulse
- DWrDone  out  1  write response pulse
- BusRdValid  out  1  read address valid toward adapter
- BusRdAddr  out  ADDR_W  latched read address
- BusRdUncache  out  1  latched uncached flag
- BusRdSel  out  1  read owner, 0 = ICache, 1 = DCache
- BusRdAccept / BusRdDone  in  1 / 1  read address handshake / last-beat pulse
- BusWrValid / BusWrAddr / BusWrUncache  out  1 / ADDR_W / 1  write request toward adapter
- BusWrAccept / BusWrDone  in  1 / 1  write address handshake / write response pulse

## Operation
- Read FSM has three states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE → R_ADDR on a grant. On the grant, latch address, uncached flag and owner.
  - R_ADDR → R_DATA on BusRdAccept.
  - R_DATA → R_IDLE on BusRdDone.
- Write FSM has three states: W_IDLE, W_ADDR, W_RESP, with the same transitions using DWrValid, BusWrAccept and BusWrDone.
- Read and write FSMs run independently. One read and one write may be outstanding at the same time.
- Read grant (R_IDLE only):
  - If only one requester is eligible, it wins.
  - If both are eligible, ICache wins unless StarveCnt == STARVE_MAX, in which case DCache wins.
- StarveCnt behaviour:
  - Increments on each ICache grant while DReqValid is high.
  - Clears on a DCache grant, or whenever DReqValid is low.
  - Saturates at STARVE_MAX.
- DCache read eligibility is DReqValid & !hazard.
  - A cached hazard is a pending write (W_ADDR/W_RESP, or a write granted this cycle) whose ADDR_W-1:LINE_OFF bits equal those of DReqAddr.
  - An uncached DCache read is hazardous whenever any write is pending.
  - ICache reads never see a hazard.
- IRespValid = BusRdDone & R_DATA & owner==0. DRespValid uses owner==1. DWrDone = BusWrDone & W_RESP.
- BusRdDone or BusRdAccept arriving outside the expected state is ignored. BusWrDone and BusWrAccept are treated the same way.

## Timing
- Grant pulses (IReqReady, DReqReady, DWrReady) are combinational in the cycle the FSM is idle and the request is eligible. The requester may drop valid the next cycle.
- BusRdValid and BusWrValid are registered. They rise the cycle after the grant and hold with stable address until the accept cycle inclusive.
- A response pulse coincides with BusRdDone or BusWrDone. The FSM is idle the next cycle, so the earliest next grant is Done+1. Back-to-back reads are therefore at least 3 cycles apart.
- Reset values: every output is 0, both FSMs are idle, StarveCnt is 0, and the latched address is 0.
- Reset mid-transaction abandons state immediately. Bus strobes arriving after reset are ignored (the adapter is reset with the same Rest).
- Same-cycle write grant and DCache read to the matching line: the write wins and the read is blocked.

## Configuration
- CACHE_ARB_RAW_CHECK_EN
  - Defined: line/uncached hazard blocking as described above.
  - Undefined: the hazard term is tied to 0. DCache reads are eligible whenever DReqValid is high, and write ordering is left to the DCache.

## Structure
- Shared package cache_arb_pkg holds:
  - read and write state encodings (2-bit each)
  - owner codes OWN_I = 1'b0, OWN_D = 1'b1
  - default LINE_OFF
- One sub-module, rd_grant_pick: purely combinational winner select from {IValid, DEligible, StarveCnt == STARVE_MAX}. It returns the one-hot grant.
- StarveCnt is $clog2(STARVE_MAX+1) bits wide.

## Test plan
- Single ICache read to 0x1C000000:
  - IReqValid cycle 0 → IReqReady cycle 0.
  - BusRdValid cycles 1–2 with BusRdSel = 0, BusRdAccept cycle 2.
  - BusRdDone cycle 6 → IRespValid cycle 6, idle cycle 7.
- ICache and DCache request in the same cycle:
  - ICache is granted first.
  - DReqReady fires the cycle after the ICache BusRdDone, with BusRdSel = 1 and BusRdAddr = the DCache address.
- STARVE_MAX = 4 with ICache requesting continuously and DCache waiting → grant order I, I, I, I, D, then I.
- Write to 0x1C000040 pending:
  - DCache read of 0x1C000048 gets no DReqReady until the cycle after DWrDone.
  - A read of 0x1C000080 is granted immediately.
  - With the macro undefined, 0x1C000048 is granted immediately.
- Uncached DCache read while any write is pending → blocked until DWrDone. An ICache read in the same window proceeds.
- Rest asserted in R_DATA and W_RESP:
  - All outputs are 0 the next cycle.
  - A BusRdDone one cycle later produces no RespValid.
